// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 3-bit-opcode core: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes, handles memory waits and traps.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [2:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             jump,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap,
    output logic [1:0]       trap_cause
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_JUMP = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_ADDI = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    state_t            r_state;
    logic [2:0]        r_op;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_count;
    logic              r_trap;
    logic [1:0]        r_cause;

    logic [2:0]        w_op;
    logic              w_timeout;
    logic              w_retire;

    // The opcode field is only valid from DECODE on, so DECODE looks at it directly.
    assign w_op      = (r_state == S_DECODE) ? opcode : r_op;
    assign w_timeout = !mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_DECODE: w_retire = (opcode == OP_NOP) || (opcode == OP_JUMP);
            S_MEM:    w_retire = mem_ready && (r_op == OP_SW);
            S_WB:     w_retire = 1'b1;
            default:  w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 3'b000;
            r_wait  <= '0;
            r_count <= '0;
            r_trap  <= 1'b0;
            r_cause <= 2'b00;
        end else begin
            r_wait <= '0;
            if (w_retire) r_count <= r_count + 1'b1;
            case (r_state)
                S_IDLE: if (run) r_state <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b10;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DECODE: begin
                    r_op <= opcode;
                    if (w_retire) begin
                        r_state <= run ? S_FETCH : S_IDLE;
                    end else if (opcode == OP_ILL) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b01;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: r_state <= (r_op == OP_LW || r_op == OP_SW) ? S_MEM : S_WB;
                S_MEM: begin
                    if (mem_ready) begin
                        r_state <= (r_op == OP_SW) ? (run ? S_FETCH : S_IDLE) : S_WB;
                    end else if (w_timeout) begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= 2'b10;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_WB:   r_state <= run ? S_FETCH : S_IDLE;
                S_TRAP: r_state <= S_TRAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        jump       = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: if (w_op == OP_JUMP) begin
                pc_write = 1'b1;
                jump     = 1'b1;
                alu_op   = 2'b01;
            end
            S_EXEC: begin
                alu_src = (w_op == OP_LW) || (w_op == OP_SW) || (w_op == OP_ADDI);
                alu_op  = (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_ADDI) ? 2'b10 : 2'b00;
            end
            S_MEM: begin
                iord      = 1'b1;
                alu_src   = 1'b1;
                mem_read  = (w_op == OP_LW);
                mem_write = (w_op == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (w_op == OP_LW);
                reg_dst    = (w_op == OP_ADD) || (w_op == OP_SUB);
            end
            default: ;
        endcase
    end

    assign done        = w_retire;
    assign busy        = (r_state != S_IDLE) && (r_state != S_TRAP);
    assign instr_count = r_count;
    assign trap        = r_trap;
    assign trap_cause  = r_cause;
endmodule
